// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, debounce, held/release tracking and a
// four-code history for a display. Define KEYPAD_REPEAT_EN to add auto-repeat.
module keypad_scan #(
    parameter int Fclk   = 50000,
    parameter int DEB_MS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    output logic [3:0]  key,
    output logic        key_vld,
    output logic        key_held,
    output logic [15:0] dat,
    output logic        ce1ms
);

    localparam int TW = $clog2(Fclk + 1);
    localparam int DW = $clog2(DEB_MS + 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(Fclk);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_MS - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ce1ms_q, ce1ms_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    rs_q, rs_d;
    logic [1:0]    c_q, c_d;
    logic [1:0]    r_q, r_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [3:0]    key_q, key_d;
    logic          key_vld_q, key_vld_d;
    logic [15:0]   dat_q, dat_d;

    logic       tick;
    logic       one_low;
    logic [1:0] row_idx;
    logic [3:0] row_pat;
    logic [3:0] code;
    logic       accept;
    logic       emit;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        tick    = (tcnt_q == TICK_MAX);
        tcnt_d  = tick ? TW'(1) : tcnt_q + TW'(1);
        ce1ms_d = tick;
        sync1_d = ROW;
        rs_d    = sync1_q;
    end

    // Exactly one low row is a valid single press; anything else keeps scanning.
    always_comb begin
        one_low = 1'b0;
        row_idx = 2'd0;
        case (rs_q)
            4'b1110: begin one_low = 1'b1; row_idx = 2'd0; end
            4'b1101: begin one_low = 1'b1; row_idx = 2'd1; end
            4'b1011: begin one_low = 1'b1; row_idx = 2'd2; end
            4'b0111: begin one_low = 1'b1; row_idx = 2'd3; end
            default: ;
        endcase
    end

    assign row_pat = ~(4'b0001 << r_q);
    assign code    = {r_q, c_q};

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        deb_d   = deb_q;
        accept  = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (one_low) begin
                        r_d     = row_idx;
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        c_d = c_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rs_q == row_pat) begin
                        if (deb_q == DEB_LAST) begin
                            state_d = HELD;
                            accept  = 1'b1;
                        end else begin
                            deb_d = deb_q + DW'(1);
                        end
                    end else begin
                        state_d = SCAN;
                        c_d     = c_q + 2'd1;
                    end
                end
                HELD: begin
                    if (rs_q == 4'hF) begin
                        deb_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rs_q == 4'hF) begin
                        if (deb_q == DEB_LAST) begin
                            state_d = SCAN;
                            c_d     = c_q + 2'd1;
                        end else begin
                            deb_d = deb_q + DW'(1);
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Down-counter in ticks: 500 to the first repeat, 100 between later ones.
    localparam logic [8:0] RPT_FIRST = 9'd500;
    localparam logic [8:0] RPT_NEXT  = 9'd100;

    logic [8:0] rpt_q, rpt_d;
    logic       rpt_fire;

    always_comb begin
        rpt_d    = rpt_q;
        rpt_fire = 1'b0;
        if (accept) begin
            rpt_d = RPT_FIRST;
        end else if (tick && state_q == HELD && rs_q != 4'hF) begin
            if (rpt_q == 9'd1) begin
                rpt_fire = 1'b1;
                rpt_d    = RPT_NEXT;
            end else begin
                rpt_d = rpt_q - 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rpt_q <= '0;
        else        rpt_q <= rpt_d;
    end

    assign emit = accept | rpt_fire;
`else
    assign emit = accept;
`endif

    always_comb begin
        key_vld_d = emit;
        key_d     = emit ? code : key_q;
        dat_d     = emit ? {dat_q[11:0], code} : dat_q;
    end

    // NOTE: state registers use non-blocking assignments only; combinational logic lives above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            tcnt_q    <= '0;
            ce1ms_q   <= 1'b0;
            sync1_q   <= 4'hF;
            rs_q      <= 4'hF;
            c_q       <= 2'd0;
            r_q       <= 2'd0;
            deb_q     <= '0;
            key_q     <= 4'd0;
            key_vld_q <= 1'b0;
            dat_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            ce1ms_q   <= ce1ms_d;
            sync1_q   <= sync1_d;
            rs_q      <= rs_d;
            c_q       <= c_d;
            r_q       <= r_d;
            deb_q     <= deb_d;
            key_q     <= key_d;
            key_vld_q <= key_vld_d;
            dat_q     <= dat_d;
        end
    end

    assign COL      = ~(4'b0001 << c_q);
    assign key      = key_q;
    assign key_vld  = key_vld_q;
    assign key_held = (state_q == HELD) || (state_q == RELEASE);
    assign dat      = dat_q;
    assign ce1ms    = ce1ms_q;

endmodule
